stream_sync_fifo: RTL and testbench



---
 rtl/stream_pkg.sv | 15 +
 rtl/stream_fifo_ram.sv | 38 +++
 rtl/stream_sync_fifo.sv | 89 ++++++++
 tb/tb_stream_sync_fifo.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared definitions for the stream blocks (FIFO, width transformer).
// Data width helper plus handshake encodings used by all stream interfaces.
package stream_pkg;

    localparam int unsigned STREAM_DEXP_DEFAULT = 0;
    localparam int unsigned STREAM_AEXP_DEFAULT = 4;

    localparam logic STREAM_VLD_ON = 1'b1;
    localparam logic STREAM_RDY_ON = 1'b1;

    function automatic int unsigned DW(input int unsigned dexp);
        return 32'd8 << dexp;
    endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// Latency: read data valid one edge after i_re. Backpressure: none, caller gates i_we/i_re.
// Kept separate so vendor tools infer block RAM without the FIFO control logic around it.
module stream_fifo_ram #(
    parameter int unsigned DW   = 8,
    parameter int unsigned AEXP = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            i_we,
    input  logic [AEXP-1:0] i_waddr,
    input  logic [DW-1:0]   i_wdata,
    input  logic            i_re,
    input  logic [AEXP-1:0] i_raddr,
    output logic [DW-1:0]   o_rdata
);

    logic [DW-1:0] r_mem [2**AEXP];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // The read register doubles as the FIFO output register, so it must reset to zero.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/stream_sync_fifo.sv
// Single-clock FWFT stream FIFO, capacity 2**AEXP words in RAM plus one output register.
// Latency: word accepted at edge k is presented with otvalid after edge k+1.
// Backpressure: itready drops when the RAM is full; output holds steady while otready is low.
module stream_sync_fifo
    import stream_pkg::*;
#(
    parameter int unsigned DEXP = 0,
    parameter int unsigned AEXP = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  itvalid,
    output logic                  itready,
    input  logic [DW(DEXP)-1:0]   itdata,
    output logic                  otvalid,
    input  logic                  otready,
    output logic [DW(DEXP)-1:0]   otdata,
    output logic [AEXP+1:0]       level
);

    localparam int unsigned W = DW(DEXP);

    logic [AEXP:0] r_wptr;
    logic [AEXP:0] r_rptr;
    logic          r_otvalid;

    logic          w_ram_empty;
    logic          w_ram_full;
    logic          w_wr;
    logic          w_load;
    logic [AEXP:0] w_used;
    logic [W-1:0]  w_rdata;

    // Flags come only from registered pointers: no same-edge read/write address collision.
    assign w_ram_empty = (r_wptr == r_rptr);
    assign w_ram_full  = (r_wptr[AEXP] != r_rptr[AEXP]) &&
                         (r_wptr[AEXP-1:0] == r_rptr[AEXP-1:0]);

    assign itready = rstn & ~w_ram_full;
    assign w_wr    = itvalid & itready;
    assign w_load  = ~w_ram_empty & (~r_otvalid | otready);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
        end else if (w_wr) begin
            r_wptr <= r_wptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rptr <= '0;
        end else if (w_load) begin
            r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_otvalid <= 1'b0;
        end else if (w_load) begin
            r_otvalid <= 1'b1;
        end else if (r_otvalid && otready) begin
            r_otvalid <= 1'b0;
        end
    end

    stream_fifo_ram #(
        .DW   (W),
        .AEXP (AEXP)
    ) u_ram (
        .clk     (clk),
        .rstn    (rstn),
        .i_we    (w_wr),
        .i_waddr (r_wptr[AEXP-1:0]),
        .i_wdata (itdata),
        .i_re    (w_load),
        .i_raddr (r_rptr[AEXP-1:0]),
        .o_rdata (w_rdata)
    );

    assign otvalid = r_otvalid;
    assign otdata  = w_rdata;

    assign w_used = r_wptr - r_rptr;
    assign level  = {1'b0, w_used} + {{(AEXP+1){1'b0}}, r_otvalid};

endmodule

// File: tb/tb_stream_sync_fifo.sv
// Bench for stream_sync_fifo: a byte-wide depth-4 instance and a 32-bit depth-8 instance,
// both compared cycle by cycle against a queue-based model of RAM contents plus output slot.
module tb_stream_sync_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic       s_itvalid, s_itready, s_otvalid, s_otready;
    logic [7:0] s_itdata, s_otdata;
    logic [3:0] s_level;

    logic        b_itvalid, b_itready, b_otvalid, b_otready;
    logic [31:0] b_itdata, b_otdata;
    logic [4:0]  b_level;

    stream_sync_fifo #(.DEXP(0), .AEXP(2)) u_small (
        .clk(clk), .rstn(rstn),
        .itvalid(s_itvalid), .itready(s_itready), .itdata(s_itdata),
        .otvalid(s_otvalid), .otready(s_otready), .otdata(s_otdata),
        .level(s_level)
    );

    stream_sync_fifo #(.DEXP(2), .AEXP(3)) u_big (
        .clk(clk), .rstn(rstn),
        .itvalid(b_itvalid), .itready(b_itready), .itdata(b_itdata),
        .otvalid(b_otvalid), .otready(b_otready), .otdata(b_otdata),
        .level(b_level)
    );

    int n_tests = 0;
    int n_fail  = 0;

    bit          sel_big = 1'b0;
    logic [31:0] dat_mask = 32'hFF;
    int          m_depth = 4;
    logic [31:0] m_ram[$];
    bit          m_ov;
    logic [31:0] m_od;
    logic [31:0] got_q[$];

    wire        obs_itready = sel_big ? b_itready : s_itready;
    wire        obs_otvalid = sel_big ? b_otvalid : s_otvalid;
    wire [31:0] obs_otdata  = sel_big ? b_otdata : {24'h0, s_otdata};
    wire [31:0] obs_level   = sel_big ? {27'h0, b_level} : {28'h0, s_level};

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ram.delete();
        m_ov = 1'b0;
        m_od = '0;
        got_q.delete();
    endtask

    task automatic select_dut(input bit big);
        sel_big  = big;
        dat_mask = big ? 32'hFFFF_FFFF : 32'h0000_00FF;
        m_depth  = big ? 8 : 4;
    endtask

    // One clock: drive, note handshakes, advance the model, compare every visible output.
    task automatic step(input bit vld, input logic [31:0] dat, input bit rdy, output bit acc);
        bit rd;
        bit ld;
        if (sel_big) begin
            b_itvalid = vld; b_itdata = dat; b_otready = rdy;
        end else begin
            s_itvalid = vld; s_itdata = dat[7:0]; s_otready = rdy;
        end
        #1;
        acc = vld && obs_itready;
        rd  = obs_otvalid && rdy;
        if (rd) got_q.push_back(obs_otdata);
        @(posedge clk);
        #1;
        ld = (m_ram.size() > 0) && (!m_ov || rd);
        if (ld) begin
            m_od = m_ram.pop_front();
            m_ov = 1'b1;
        end else if (rd) begin
            m_ov = 1'b0;
        end
        if (acc) m_ram.push_back(dat & dat_mask);
        chk_eq("otvalid", {31'h0, obs_otvalid}, {31'h0, m_ov});
        chk_eq("otdata", obs_otdata, m_od);
        chk_eq("itready", {31'h0, obs_itready}, (m_ram.size() < m_depth) ? 32'd1 : 32'd0);
        chk_eq("level", obs_level, 32'(m_ram.size()) + 32'(m_ov));
    endtask

    initial begin
        bit acc;
        rstn = 1'b0;
        s_itvalid = 0; s_itdata = 0; s_otready = 0;
        b_itvalid = 0; b_itdata = 0; b_otready = 0;
        m_reset();
        #2;
        chk_eq("rst_s_itready", {31'h0, s_itready}, 0);
        chk_eq("rst_s_otvalid", {31'h0, s_otvalid}, 0);
        chk_eq("rst_s_level", {28'h0, s_level}, 0);
        chk_eq("rst_b_itready", {31'h0, b_itready}, 0);
        chk_eq("rst_b_otdata", b_otdata, 0);
        chk_eq("rst_b_level", {27'h0, b_level}, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // Fill with otready low: 2-cycle fall-through, then full after 5 words.
        select_dut(1'b0);
        step(1'b1, 32'h01, 1'b0, acc);
        chk_eq("lat_e1_otvalid", {31'h0, s_otvalid}, 0);
        step(1'b1, 32'h02, 1'b0, acc);
        chk_eq("lat_e2_otvalid", {31'h0, s_otvalid}, 1);
        chk_eq("lat_e2_otdata", {24'h0, s_otdata}, 32'h01);
        for (int i = 3; i <= 5; i++) step(1'b1, 32'(i), 1'b0, acc);
        chk_eq("fill_level", {28'h0, s_level}, 5);
        chk_eq("fill_itready", {31'h0, s_itready}, 0);
        step(1'b1, 32'h06, 1'b0, acc);
        chk_eq("fill_6th_acc", {31'h0, acc}, 0);
        chk_eq("fill_6th_level", {28'h0, s_level}, 5);

        // Drain from full.
        s_itvalid = 1'b0;
        step(1'b0, 32'h0, 1'b1, acc);
        chk_eq("drain_itready", {31'h0, s_itready}, 1);
        chk_eq("drain_lvl4", {28'h0, s_level}, 4);
        for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b1, acc);
        chk_eq("drain_count", 32'(got_q.size()), 5);
        for (int i = 0; i < got_q.size() && i < 5; i++)
            chk_eq("drain_order", got_q[i], 32'(i + 1));
        chk_eq("drain_otvalid", {31'h0, s_otvalid}, 0);
        chk_eq("drain_level", {28'h0, s_level}, 0);

        // Pointer wrap: bursty push/pop of 37 words through a 4-deep RAM.
        begin : wrap_blk
            int pushed;
            int cyc;
            bit v;
            bit r;
            pushed = 0;
            cyc = 0;
            got_q.delete();
            while ((pushed < 37 || got_q.size() < 37) && cyc < 1000) begin
                v = (pushed < 37) && ((cyc % 5) != 4);
                r = (cyc % 7) < 3;
                step(v, 32'h40 + 32'(pushed), r, acc);
                if (acc) pushed++;
                cyc++;
            end
            chk_eq("wrap_count", 32'(got_q.size()), 37);
            for (int i = 0; i < got_q.size() && i < 37; i++)
                chk_eq("wrap_order", got_q[i], 32'h40 + 32'(i));
        end

        // Asynchronous reset with three words held.
        for (int i = 0; i < 3; i++) step(1'b1, 32'h11 * 32'(i + 1), 1'b0, acc);
        chk_eq("prerst_level", {28'h0, s_level}, 3);
        s_itvalid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_eq("arst_otvalid", {31'h0, s_otvalid}, 0);
        chk_eq("arst_itready", {31'h0, s_itready}, 0);
        chk_eq("arst_level", {28'h0, s_level}, 0);
        m_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        step(1'b1, 32'hAA, 1'b1, acc);
        for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, acc);
        chk_eq("post_rst_count", 32'(got_q.size()), 1);
        if (got_q.size() > 0) chk_eq("post_rst_word", got_q[0], 32'hAA);

        // Continuous streaming on the 32-bit instance.
        select_dut(1'b1);
        m_reset();
        begin : stream_blk
            int gaps;
            int hi_lvl;
            int bad;
            int n_acc;
            gaps = 0; hi_lvl = 0; bad = 0; n_acc = 0;
            for (int i = 0; i < 1000; i++) begin
                step(1'b1, 32'(i), 1'b1, acc);
                if (acc) n_acc++;
                if (i >= 1 && !b_otvalid) gaps++;
                if (i >= 1 && (b_level < 1 || b_level > 2)) hi_lvl++;
            end
            for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1, acc);
            chk_eq("stream_accepted", 32'(n_acc), 1000);
            chk_eq("stream_gaps", 32'(gaps), 0);
            chk_eq("stream_lvl_out", 32'(hi_lvl), 0);
            chk_eq("stream_count", 32'(got_q.size()), 1000);
            for (int i = 0; i < got_q.size(); i++) if (got_q[i] !== 32'(i)) bad++;
            chk_eq("stream_order", 32'(bad), 0);
        end

        // Random valid/ready at 50% each.
        begin : rand_blk
            logic [31:0] sent_q[$];
            logic [31:0] pend;
            logic [31:0] prev_dat;
            bit          prev_hold;
            bit          v;
            bit          r;
            int          cyc;
            int          max_lvl;
            int          bad;
            got_q.delete();
            pend = $urandom;
            cyc = 0; max_lvl = 0; bad = 0;
            while (got_q.size() < 10000 && cyc < 60000) begin
                v = (sent_q.size() < 10000) && ($urandom_range(0, 1) == 1);
                r = ($urandom_range(0, 1) == 1);
                prev_hold = b_otvalid && !r;
                prev_dat  = b_otdata;
                step(v, pend, r, acc);
                if (acc) begin
                    sent_q.push_back(pend);
                    pend = $urandom;
                end
                if (prev_hold) begin
                    chk_eq("hold_vld", {31'h0, b_otvalid}, 1);
                    chk_eq("hold_dat", b_otdata, prev_dat);
                end
                if (int'(b_level) > max_lvl) max_lvl = int'(b_level);
                cyc++;
            end
            chk_eq("rand_count", 32'(got_q.size()), 10000);
            for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
                if (got_q[i] !== sent_q[i]) bad++;
            chk_eq("rand_order", 32'(bad), 0);
            chk_eq("rand_max_lvl_ok", (max_lvl <= 9) ? 32'd1 : 32'd0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
